// File: rtl/systolic_os_array.sv
// Output-stationary N x N systolic matrix-multiply engine.
// Operands enter through internal diagonal skew lines. Each PE accumulates a*b in place.
// Result rows drain one per handshake through a valid/ready port.
module systolic_os_array #(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 21,
  parameter int K_WIDTH    = 9
) (
  input  logic                                  clk,
  input  logic                                  srst,
  input  logic                                  start,
  input  logic                                  accumulate,
  input  logic [K_WIDTH-1:0]                    k_len,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]      in_a,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]      in_b,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [$clog2(ARRAY_SIZE)-1:0]         out_row,
  output logic [ARRAY_SIZE*ACC_WIDTH-1:0]       out_data,
  output logic                                  busy,
  output logic                                  done
);

  localparam int N  = ARRAY_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int RW = $clog2(ARRAY_SIZE);
  localparam int FW = $clog2(2 * ARRAY_SIZE);
  localparam logic [K_WIDTH-1:0] K_ONE      = {{(K_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [K_WIDTH-1:0] K_ZERO     = {K_WIDTH{1'b0}};
  localparam logic [FW-1:0]      FLUSH_LAST = FW'(2 * ARRAY_SIZE - 2);
  localparam logic [RW-1:0]      ROW_LAST   = RW'(ARRAY_SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic [K_WIDTH-1:0]   beat_cnt_r, k_len_r;
  logic [FW-1:0]        flush_cnt_r;
  logic [RW-1:0]        out_row_r;
  logic                 done_r;

  logic start_s, clear_s, accept_s, last_beat_s, flush_last_s;
  logic handshake_s, last_row_s, mac_en_s;

  logic signed [DW-1:0] feed_a_s [N];
  logic signed [DW-1:0] feed_b_s [N];
  logic signed [DW-1:0] skew_a_s [N];
  logic signed [DW-1:0] skew_b_s [N];
  logic signed [DW-1:0] a_out_s  [N][N];
  logic signed [DW-1:0] b_out_s  [N][N];
  logic signed [AW-1:0] acc_s    [N][N];

  assign start_s      = (state_r == ST_IDLE) && start;
  assign clear_s      = start_s && !accumulate;
  assign accept_s     = (state_r == ST_LOAD) && in_valid;
  assign last_beat_s  = accept_s && (beat_cnt_r == (k_len_r - K_ONE));
  assign flush_last_s = (flush_cnt_r == FLUSH_LAST);
  assign handshake_s  = (state_r == ST_DRAIN) && out_ready;
  assign last_row_s   = (out_row_r == ROW_LAST);
  // Operands and accumulators only move while beats or flush zeros are flowing.
  assign mac_en_s     = (state_r == ST_LOAD) || (state_r == ST_FLUSH);

  assign in_ready  = (state_r == ST_LOAD);
  assign out_valid = (state_r == ST_DRAIN);
  assign busy      = (state_r != ST_IDLE);
  assign done      = done_r;
  assign out_row   = out_row_r;

  // State register
  always_ff @(posedge clk) begin
    if (srst) state_r <= ST_IDLE;
    else      state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = (k_len == K_ZERO) ? ST_FLUSH : ST_LOAD;
        else       state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (last_beat_s) state_s = ST_FLUSH;
        else             state_s = ST_LOAD;
      end
      ST_FLUSH: begin
        if (flush_last_s) state_s = ST_DRAIN;
        else              state_s = ST_FLUSH;
      end
      ST_DRAIN: begin
        if (handshake_s && last_row_s) state_s = ST_IDLE;
        else                           state_s = ST_DRAIN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Beat and flush counters; k_len is captured with start
  always_ff @(posedge clk) begin
    if (srst) begin
      beat_cnt_r  <= K_ZERO;
      k_len_r     <= K_ZERO;
      flush_cnt_r <= {FW{1'b0}};
    end else begin
      if (start_s) begin
        k_len_r    <= k_len;
        beat_cnt_r <= K_ZERO;
      end else if (accept_s) begin
        beat_cnt_r <= beat_cnt_r + K_ONE;
      end
      if (state_r == ST_FLUSH) flush_cnt_r <= flush_last_s ? {FW{1'b0}} : flush_cnt_r + {{(FW-1){1'b0}}, 1'b1};
      else                     flush_cnt_r <= {FW{1'b0}};
    end
  end

  // Drain row pointer and done pulse
  always_ff @(posedge clk) begin
    if (srst) begin
      out_row_r <= {RW{1'b0}};
      done_r    <= 1'b0;
    end else begin
      done_r <= handshake_s && last_row_s;
      if (handshake_s) out_row_r <= last_row_s ? {RW{1'b0}} : out_row_r + {{(RW-1){1'b0}}, 1'b1};
    end
  end

  // Lane feed: bubbles and non-LOAD cycles inject zeros so they add nothing
  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (accept_s) begin
        feed_a_s[i] = in_a[i*DW +: DW];
        feed_b_s[i] = in_b[i*DW +: DW];
      end else begin
        feed_a_s[i] = {DW{1'b0}};
        feed_b_s[i] = {DW{1'b0}};
      end
    end
  end

  // Skew lines: lane i is delayed i cycles so operands meet on the diagonal wavefront
  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign skew_a_s[i] = feed_a_s[i];
      assign skew_b_s[i] = feed_b_s[i];
    end else begin : g_delay
      logic signed [DW-1:0] dly_a_r [i];
      logic signed [DW-1:0] dly_b_r [i];
      // Shift lane operands one stage per active cycle
      always_ff @(posedge clk) begin
        if (srst) begin
          for (int d = 0; d < i; d++) begin
            dly_a_r[d] <= {DW{1'b0}};
            dly_b_r[d] <= {DW{1'b0}};
          end
        end else if (mac_en_s) begin
          dly_a_r[0] <= feed_a_s[i];
          dly_b_r[0] <= feed_b_s[i];
          for (int d = 1; d < i; d++) begin
            dly_a_r[d] <= dly_a_r[d-1];
            dly_b_r[d] <= dly_b_r[d-1];
          end
        end
      end
      assign skew_a_s[i] = dly_a_r[i-1];
      assign skew_b_s[i] = dly_b_r[i-1];
    end
  end

  // PE grid: a flows right, b flows down, the accumulator stays put
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_pe
      logic signed [DW-1:0]   a_in_s, b_in_s, a_r, b_r;
      logic signed [2*DW-1:0] a_ext_s, b_ext_s, prod_s;
      logic signed [AW-1:0]   prod_ext_s, acc_r;

      if (j == 0) begin : g_a_edge
        assign a_in_s = skew_a_s[i];
      end else begin : g_a_int
        assign a_in_s = a_out_s[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_in_s = skew_b_s[j];
      end else begin : g_b_int
        assign b_in_s = b_out_s[i-1][j];
      end

      // Full-precision signed product, then sign-extended; the sum wraps modulo 2^AW
      assign a_ext_s    = $signed({{DW{a_in_s[DW-1]}}, a_in_s});
      assign b_ext_s    = $signed({{DW{b_in_s[DW-1]}}, b_in_s});
      assign prod_s     = a_ext_s * b_ext_s;
      assign prod_ext_s = $signed({{(AW-2*DW){prod_s[2*DW-1]}}, prod_s});

      // Operand pass-through registers
      always_ff @(posedge clk) begin
        if (srst) begin
          a_r <= {DW{1'b0}};
          b_r <= {DW{1'b0}};
        end else if (mac_en_s) begin
          a_r <= a_in_s;
          b_r <= b_in_s;
        end
      end

      // Accumulator: cleared on a non-accumulating start, otherwise held outside LOAD/FLUSH
      always_ff @(posedge clk) begin
        if (srst)          acc_r <= {AW{1'b0}};
        else if (clear_s)  acc_r <= {AW{1'b0}};
        else if (mac_en_s) acc_r <= acc_r + prod_ext_s;
      end

      assign a_out_s[i][j] = a_r;
      assign b_out_s[i][j] = b_r;
      assign acc_s[i][j]   = acc_r;
    end
  end

  // Present the selected row; accumulators are frozen while draining
  always_comb begin
    out_data = {(N*AW){1'b0}};
    for (int j = 0; j < N; j++) begin
      out_data[j*AW +: AW] = acc_s[out_row_r][j];
    end
  end

endmodule
